// File: rtl/rv32_e_div_sequencer_if.sv
// Execute-stage divide port bundle: request side (start/flush/op/operands) and result side.
// The E stage holds start_i high while stall_o is high; a result is taken in the single cycle valid_o is high.
interface rv32_e_div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [1:0]      dbg_state_o;

  modport master (
    output start_i, flush_i, op_i, src_a_i, src_b_i,
    input  stall_o, busy_o, valid_o, result_o, dbg_state_o
  );

  modport slave (
    input  start_i, flush_i, op_i, src_a_i, src_b_i,
    output stall_o, busy_o, valid_o, result_o, dbg_state_o
  );
endinterface

// File: rtl/rv32_e_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: latches operands, runs a radix-2 restoring divide over XLEN
// cycles while stalling the pipeline, and pulses valid_o with the architectural result.
module rv32_e_div_sequencer #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  rv32_e_div_sequencer_if.slave  sif
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_spec_res;
  logic [CW-1:0]   r_count;
  logic            r_want_rem;
  logic            r_qneg;
  logic            r_rneg;
  logic            r_spec;

  // Operand conditioning, evaluated in the IDLE cycle that samples start_i.
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_spec;
  logic [XLEN-1:0] w_spec_res;

  always_comb begin
    w_signed   = ~sif.op_i[0];
    w_a_neg    = w_signed & sif.src_a_i[XLEN-1];
    w_b_neg    = w_signed & sif.src_b_i[XLEN-1];
    w_abs_a    = w_a_neg ? (~sif.src_a_i + ONE) : sif.src_a_i;
    w_abs_b    = w_b_neg ? (~sif.src_b_i + ONE) : sif.src_b_i;
    w_b_zero   = (sif.src_b_i == '0);
    w_ovf      = w_signed & (sif.src_a_i == INT_MIN) & (sif.src_b_i == '1);
    w_spec     = w_b_zero | w_ovf;
    w_spec_res = '0;
    if (w_b_zero) begin
      w_spec_res = sif.op_i[1] ? sif.src_a_i : '1;
    end else begin
      w_spec_res = sif.op_i[1] ? '0 : INT_MIN;
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor when it fits (the borrow bit of the wide subtract decides).
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_q_nx;
  logic [XLEN-1:0] w_quot_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_final;

  always_comb begin
    w_shift    = {r_rem, r_q[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_div};
    w_fits     = ~w_diff[XLEN];
    w_rem_nx   = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    w_q_nx     = {r_q[XLEN-2:0], w_fits};
    w_quot_fix = r_qneg ? (~w_q_nx + ONE) : w_q_nx;
    w_rem_fix  = r_rneg ? (~w_rem_nx + ONE) : w_rem_nx;
    w_final    = r_spec ? r_spec_res : (r_want_rem ? w_rem_fix : w_quot_fix);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_result   <= '0;
      r_spec_res <= '0;
      r_count    <= '0;
      r_want_rem <= 1'b0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_spec     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!sif.flush_i && sif.start_i) begin
            // Forwarded sources may disappear while stalled, so everything is captured here.
            r_q        <= w_abs_a;
            r_rem      <= '0;
            r_div      <= w_abs_b;
            r_want_rem <= sif.op_i[1];
            r_qneg     <= w_a_neg ^ w_b_neg;
            r_rneg     <= w_a_neg;
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            if (EARLY_OUT && w_spec) begin
              r_result <= w_spec_res;
              r_state  <= S_DONE;
            end else begin
              r_count <= LAST;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // A dropped start_i means the instruction left E without a flush; abort the same way.
          if (sif.flush_i || !sif.start_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_q   <= w_q_nx;
            if (r_count == '0) begin
              r_result <= w_final;
              r_state  <= S_DONE;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  logic w_valid;
  assign w_valid         = (r_state == S_DONE);
  assign sif.valid_o     = w_valid;
  assign sif.busy_o      = (r_state != S_IDLE);
  assign sif.result_o    = r_result;
  assign sif.stall_o     = sif.start_i & ~w_valid & ~sif.flush_i;
  assign sif.dbg_state_o = r_state;

endmodule

// File: tb/tb_rv32_e_div_sequencer.sv
// Bench for rv32_e_div_sequencer: directed cases plus randomized ops against an arithmetic model,
// run on an EARLY_OUT=1 instance (u_dut1) and an EARLY_OUT=0 instance (u_dut0) sharing inputs.
module tb_rv32_e_div_sequencer;
  localparam int XLEN = 32;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rv32_e_div_sequencer_if #(.XLEN(XLEN)) dif1 ();
  rv32_e_div_sequencer_if #(.XLEN(XLEN)) dif0 ();

  assign dif0.start_i = dif1.start_i;
  assign dif0.flush_i = dif1.flush_i;
  assign dif0.op_i    = dif1.op_i;
  assign dif0.src_a_i = dif1.src_a_i;
  assign dif0.src_b_i = dif1.src_b_i;

  rv32_e_div_sequencer #(.XLEN(XLEN), .EARLY_OUT(1'b1)) u_dut1 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sif     (dif1)
  );

  rv32_e_div_sequencer #(.XLEN(XLEN), .EARLY_OUT(1'b0)) u_dut0 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sif     (dif0)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [XLEN-1:0] ref_div(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic sel_sig(input int sel, input logic s1, input logic s0);
    return (sel == 1) ? s1 : s0;
  endfunction

  // Issue one divide to both instances, judge the one picked by sel against expv.
  task automatic do_op(input string tag, input int sel, input logic [1:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] expv, input bit scramble);
    int lat_exp;
    int cyc;
    bit got;
    bit stall_ok;
    lat_exp = (sel == 1 && is_special(op, a, b)) ? 1 : 33;
    exp_q.push_back(expv);
    @(negedge clk_i);
    dif1.start_i = 1'b1;
    dif1.op_i    = op;
    dif1.src_a_i = a;
    dif1.src_b_i = b;
    #1;
    check({tag, "_stall_c0"}, 32'(sel_sig(sel, dif1.stall_o, dif0.stall_o)), 32'd1);
    cyc = 0;
    got = 1'b0;
    stall_ok = 1'b1;
    while (!got && cyc < 40) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (sel_sig(sel, dif1.valid_o, dif0.valid_o)) begin
        got = 1'b1;
      end else begin
        if (!sel_sig(sel, dif1.stall_o, dif0.stall_o)) stall_ok = 1'b0;
        if (scramble) begin
          dif1.src_a_i = $urandom;
          dif1.src_b_i = $urandom;
        end
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
    check({tag, "_result"}, (sel == 1) ? dif1.result_o : dif0.result_o, exp_q.pop_front());
    check({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
    check({tag, "_stall_valid"}, 32'(sel_sig(sel, dif1.stall_o, dif0.stall_o)), 32'd0);
    last_res = expv;
    dif1.start_i = 1'b0;
    @(posedge clk_i);
    #1;
    check({tag, "_pulse"}, 32'(sel_sig(sel, dif1.valid_o, dif0.valid_o)), 32'd0);
    check({tag, "_idle"}, 32'(sel_sig(sel, dif1.busy_o, dif0.busy_o)), 32'd0);
  endtask

  initial begin
    logic [1:0] op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    bit no_valid;

    dif1.start_i = 1'b0;
    dif1.flush_i = 1'b0;
    dif1.op_i    = 2'b00;
    dif1.src_a_i = '0;
    dif1.src_b_i = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(dif1.busy_o), 32'd0);
    check("rst_valid", 32'(dif1.valid_o), 32'd0);
    check("rst_result", dif1.result_o, 32'd0);
    check("rst_busy0", 32'(dif0.busy_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Unsigned, signed and special-case directed ops
    do_op("divu_100_7", 1, 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
    do_op("remu_100_7", 1, 2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
    do_op("div_m7_2", 1, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_m7_2", 1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op("div_7_m2", 1, 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_7_m2", 1, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    do_op("divu_5_0_e1", 1, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("divu_5_0_e0", 0, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("remu_5_0_e1", 1, 2'b11, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op("remu_5_0_e0", 0, 2'b11, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op("div_m7_0_e0", 0, 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("div_ovf_e1", 1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("rem_ovf_e1", 1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op("div_ovf_e0", 0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("divu_scramble", 1, 2'b01, 32'd100, 32'd7, 32'd14, 1'b1);

    // Flush at cycle 10 of DIVU 100/7, then DIVU 9/3 at cycle 12
    @(negedge clk_i);
    dif1.start_i = 1'b1;
    dif1.op_i    = 2'b01;
    dif1.src_a_i = 32'd100;
    dif1.src_b_i = 32'd7;
    no_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      if (dif1.valid_o || dif0.valid_o) no_valid = 1'b0;
    end
    dif1.flush_i = 1'b1;
    #1;
    check("flush_stall", 32'(dif1.stall_o), 32'd0);
    @(posedge clk_i);
    #1;
    dif1.flush_i = 1'b0;
    dif1.start_i = 1'b0;
    check("flush_no_valid_run", 32'(no_valid), 32'd1);
    check("flush_busy", 32'(dif1.busy_o), 32'd0);
    check("flush_valid", 32'(dif1.valid_o), 32'd0);
    check("flush_result_held", dif1.result_o, last_res);
    @(posedge clk_i);
    #1;
    do_op("divu_9_3_after_flush", 1, 2'b01, 32'd9, 32'd3, 32'd3, 1'b0);

    // Asynchronous reset mid-BUSY
    @(negedge clk_i);
    dif1.start_i = 1'b1;
    dif1.op_i    = 2'b01;
    dif1.src_a_i = 32'd1000;
    dif1.src_b_i = 32'd3;
    repeat (6) @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    dif1.start_i = 1'b0;
    #1;
    check("arst_busy", 32'(dif1.busy_o), 32'd0);
    check("arst_valid", 32'(dif1.valid_o), 32'd0);
    check("arst_result", dif1.result_o, 32'd0);
    check("arst_stall", 32'(dif1.stall_o), 32'd0);
    check("arst_result0", dif0.result_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("arst_stays_idle", 32'(dif1.busy_o), 32'd0);

    // Randomized ops against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 15)); end
        3: b = 32'($urandom_range(1, 9)) | (b & 32'h8000_0000);
        default: ;
      endcase
      do_op($sformatf("rnd%0d", n), int'($urandom_range(0, 1)), op, a, b, ref_div(op, a, b),
            bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
